// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 constants, FSM states and funct3 legality check
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Stores only come in b/h/w; loads additionally allow the unsigned b/h forms.
  function automatic logic is_legal_funct3(input logic we, input logic [2:0] funct3);
    logic legal;
    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!we) begin
      legal = legal || (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return legal;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and extension for loads
// Ports:
//   lane        byte offset within the word (addr[1:0])
//   funct3      load/store size and signedness
//   wdata       right-justified store data
//   rdata_word  full word read from storage
//   be          per-byte write enables
//   wdata_lane  store data replicated onto the addressed lanes
//   rdata_ext   sign/zero extended load result
//   misalign    access does not sit on its natural boundary
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Size lives in funct3[1:0]; signedness only matters for loads.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    misalign   = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = lane[0];
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misalign   = (lane != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata_word[7:0];
    case (lane)
      2'd0: byte_sel = rdata_word[7:0];
      2'd1: byte_sel = rdata_word[15:8];
      2'd2: byte_sel = rdata_word[23:16];
      2'd3: byte_sel = rdata_word[31:24];
      default: ;
    endcase
    half_sel = lane[1] ? rdata_word[31:16] : rdata_word[15:0];
  end

  always_comb begin
    rdata_ext = 32'h0;
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata_ext = rdata_word;
      F3_BU:   rdata_ext = {24'h0, byte_sel};
      F3_HU:   rdata_ext = {16'h0, half_sel};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store memory responder with wait states and error reporting
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready                request handshake
//   req_we/req_addr/req_wdata/req_funct3  request fields
//   resp_valid/resp_ready              response handshake
//   resp_rdata/resp_err                extended load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          oor_q, oor_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   ram [DEPTH];
  logic [31:0]   rd_word;
  logic [31:0]   word_idx;
  logic [3:0]    be;
  logic [31:0]   wr_lane;
  logic [31:0]   ld_ext;
  logic          misalign;
  logic          acc_err;
  logic          commit;

  assign word_idx = {2'b00, req_addr[31:2]};
  assign rd_word  = ram[idx_q];

  dmem_lane_align u_align (
    .lane       (lane_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .rdata_word (rd_word),
    .be         (be),
    .wdata_lane (wr_lane),
    .rdata_ext  (ld_ext),
    .misalign   (misalign)
  );

  // Range is judged on the full address at acceptance; alignment and funct3
  // legality come from the latched fields, so the error is final by ACCESS.
  assign acc_err = oor_q | misalign | ~is_legal_funct3(we_q, f3_q);
  assign commit  = (state_q == ACCESS) & we_q & ~acc_err;

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    lane_d       = lane_q;
    idx_d        = idx_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    oor_d        = oor_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          lane_d  = req_addr[1:0];
          idx_d   = req_addr[AW+1:2];
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          oor_d   = (word_idx >= 32'(DEPTH));
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        resp_err_d   = acc_err;
        resp_rdata_d = (we_q | acc_err) ? 32'h0 : ld_ext;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      lane_q       <= 2'd0;
      idx_q        <= '0;
      f3_q         <= 3'd0;
      wdata_q      <= 32'h0;
      oor_q        <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      lane_q       <= lane_d;
      idx_q        <= idx_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is not reset; reset only blocks a commit that would happen this edge.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ram[idx_q][8*b +: 8] <= wr_lane[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at two wait-state settings
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [2][DEPTH];
  int          wait_of [2] = '{0, 3};
  logic [31:0] last_rdata;
  logic        last_err;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed view of memory; size/sign from funct3 as a table.
  task automatic model_ref(input int s, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           output logic [31:0] rdata, output bit err);
    int     nbytes;
    bit     sgn;
    bit     legal;
    longint widx;
    int     lane;
    longint v;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1; end
      3'd1: begin nbytes = 2; sgn = 1; end
      3'd2: begin nbytes = 4; sgn = 0; end
      3'd4: begin nbytes = 1; sgn = 0; end
      3'd5: begin nbytes = 2; sgn = 0; end
      default: begin nbytes = 0; sgn = 0; end
    endcase
    legal = we ? (f3 <= 3'd2) : (nbytes != 0);
    widx  = longint'(addr) / 4;
    lane  = int'(addr % 4);
    err   = !legal || (nbytes > 0 && (lane % nbytes) != 0) || (widx >= DEPTH);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++)
          mem[s][widx][8*(lane+i) +: 8] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nbytes; i++)
          v = v + (longint'(mem[s][widx][8*(lane+i) +: 8]) << (8*i));
        if (sgn && v >= (64'sd1 << (8*nbytes-1)))
          v = v - (64'sd1 << (8*nbytes));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic txn(input int s, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3, input int hold);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    bit          keep;
    model_ref(s, we, addr, wdata, f3, exp_rd, exp_err);
    keep = 1'($urandom_range(0, 1));
    chk("ready_in_idle", 32'(req_ready[s]), 32'd1);
    req_valid[s]  = 1'b1;
    req_we[s]     = we;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    req_funct3[s] = f3;
    @(posedge clk); #1;
    if (keep) begin
      req_we[s]     = ~we;
      req_addr[s]   = $urandom;
      req_wdata[s]  = $urandom;
      req_funct3[s] = 3'($urandom_range(0, 7));
    end else begin
      req_valid[s] = 1'b0;
    end
    n = 0;
    while (resp_valid[s] !== 1'b1 && n < 64) begin
      chk("ready_low_busy", 32'(req_ready[s]), 32'd0);
      resp_ready[s] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    resp_ready[s] = 1'b0;
    chk("resp_latency", 32'(n), 32'(wait_of[s] + 1));
    chk("resp_rdata", resp_rdata[s], exp_rd);
    chk("resp_err", 32'(resp_err[s]), 32'(exp_err));
    last_rdata = resp_rdata[s];
    last_err   = resp_err[s];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid[s]), 32'd1);
      chk("hold_rdata", resp_rdata[s], exp_rd);
      chk("hold_ready_low", 32'(req_ready[s]), 32'd0);
    end
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
    req_valid[s]  = 1'b0;
    chk("idle_after_hs", 32'(req_ready[s]), 32'd1);
    chk("valid_drop", 32'(resp_valid[s]), 32'd0);
  endtask

  task automatic rand_txns(input int s, input int count);
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < count; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = 32'(4*DEPTH) + $urandom_range(0, 255);
      else                           addr = $urandom_range(0, 63);
      txn(s, we, addr, $urandom, f3, $urandom_range(0, 4));
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 32'h0;
      req_wdata[s] = 32'h0; req_funct3[s] = 3'h0; resp_ready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[s], 32'h0);
      chk("rst_resp_err", 32'(resp_err[s]), 32'd0);
    end

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        txn(s, 1'b1, 32'(4*w), $urandom, 3'b010, 0);

    txn(0, 1'b1, 32'h64, 32'h19, 3'b010, 0);
    txn(0, 1'b0, 32'h64, 32'h0, 3'b010, 0);
    chk("lw_0x64", last_rdata, 32'h19);

    txn(0, 1'b1, 32'h0, 32'h8001FF7F, 3'b010, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 3'b000, 0); chk("lb_0",   last_rdata, 32'h0000007F);
    txn(0, 1'b0, 32'h0, 32'h0, 3'b100, 0); chk("lbu_0",  last_rdata, 32'h0000007F);
    txn(0, 1'b0, 32'h1, 32'h0, 3'b000, 1); chk("lb_1",   last_rdata, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'h1, 32'h0, 3'b100, 0); chk("lbu_1",  last_rdata, 32'h000000FF);
    txn(0, 1'b0, 32'h2, 32'h0, 3'b001, 2); chk("lh_2",   last_rdata, 32'hFFFF8001);
    txn(0, 1'b0, 32'h2, 32'h0, 3'b101, 0); chk("lhu_2",  last_rdata, 32'h00008001);

    txn(0, 1'b1, 32'h4, 32'h11223344, 3'b010, 0);
    txn(0, 1'b1, 32'h6, 32'hAB, 3'b000, 0);
    txn(0, 1'b0, 32'h4, 32'h0, 3'b010, 0); chk("after_sb", last_rdata, 32'h11AB3344);
    txn(0, 1'b1, 32'h4, 32'hCDEF, 3'b001, 0);
    txn(0, 1'b0, 32'h4, 32'h0, 3'b010, 0); chk("after_sh", last_rdata, 32'h11ABCDEF);

    txn(0, 1'b1, 32'hC, 32'h5A5A1234, 3'b010, 0);
    txn(0, 1'b0, 32'hD, 32'h0, 3'b010, 0);
    chk("err_lw_mis", 32'(last_err), 32'd1); chk("err_lw_mis_data", last_rdata, 32'h0);
    txn(0, 1'b1, 32'hF, 32'hFFFF, 3'b001, 0);
    chk("err_sh_mis", 32'(last_err), 32'd1); chk("err_sh_mis_data", last_rdata, 32'h0);
    txn(0, 1'b0, 32'hC, 32'h0, 3'b011, 0);
    chk("err_f3_011", 32'(last_err), 32'd1); chk("err_f3_011_data", last_rdata, 32'h0);
    txn(0, 1'b1, 32'(4*DEPTH), 32'hDEADBEEF, 3'b010, 0);
    chk("err_oor", 32'(last_err), 32'd1); chk("err_oor_data", last_rdata, 32'h0);
    txn(0, 1'b0, 32'hC, 32'h0, 3'b010, 0); chk("ram3_kept", last_rdata, 32'h5A5A1234);

    txn(1, 1'b0, 32'h64 - 32'h64 + 32'h8, 32'h0, 3'b010, 5);
    txn(1, 1'b1, 32'h10, 32'h0BADF00D, 3'b010, 5);
    txn(1, 1'b0, 32'h12, 32'h0, 3'b001, 5); chk("w3_lh", last_rdata, 32'h00000BAD);

    // Reset lands on the ACCESS cycle of a store: nothing commits, no response.
    txn(0, 1'b1, 32'h8, 32'hA1B2C3D4, 3'b010, 0);
    chk("ready_pre_rst", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8;
    req_wdata[0] = 32'h77; req_funct3[0] = 3'b000;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    chk("rst_acc_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_acc_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_acc_rdata", resp_rdata[0], 32'h0);
    @(posedge clk); #1;
    chk("rst_acc_novalid", 32'(resp_valid[0]), 32'd0);
    txn(0, 1'b0, 32'h8, 32'h0, 3'b010, 0); chk("ram2_kept", last_rdata, 32'hA1B2C3D4);

    rand_txns(0, 60);
    rand_txns(1, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
